dpram_bwc: RTL
==============

// Module: dpram_bwc
// PURPOSE
//  Parametrised true-dual-clocked-once dual-port RAM with byte-lane write enables, selectable
//  read-during-write behaviour and a self-clearing sweep FSM. Port 1 is read-only (video/fetch
//  side), port 2 is read/write (CPU side). Used for framebuffers and register files that must
//  come out of reset in a known state.
// PARAMETERS
//  AW     14      address width; depth = 2**AW words
//  DW     8       data width; must be a multiple of 8
//  RDW1   0       port-1 read vs same-cycle port-2 write to same address: 0 = old data, 1 = new data (bypass)
//  RDW2   0       port-2 output on its own write: 0 = q2 holds, 1 = q2 <= merged written word
//  CLRV   0       word value written to every location by the clear sweep
// PORTS
//  clock  in   1       single clock, all logic on rising edge
//  reset  in   1       asynchronous, active-high
//  clr    in   1       synchronous clear request, sampled only while ready=1
//  ready  out  1       1 = sweep finished, ports accepted
//  ce1    in   1       port-1 enable
//  a1     in   AW      port-1 address
//  q1     out  DW      port-1 read data
//  ce2    in   1       port-2 enable
//  we2    in   1       port-2 write strobe, active-LOW (0 = write, 1 = read)
//  be2    in   DW/8    port-2 byte-lane enables, active-high, bit i -> d2[8i+7:8i]
//  d2     in   DW      port-2 write data
//  a2     in   AW      port-2 address
//  q2     out  DW      port-2 read data
// BEHAVIOUR
//  - Reset (async assert, sync release): q1=0, q2=0, ready=0, FSM=CLEAR, sweep counter=0.
//  - FSM states: CLEAR -> IDLE.  CLEAR writes CLRV to address cnt, cnt++ each cycle; after
//    address 2**AW-1 is written, next cycle state=IDLE, ready=1 (sweep = 2**AW cycles + 1).
//  - IDLE: clr=1 -> CLEAR, cnt=0, ready=0 the following cycle. clr ignored while in CLEAR.
//  - During CLEAR: ce1/ce2 ignored, no user writes, q1/q2 hold their values.
//  - Reset mid-sweep: sweep restarts from address 0 after release.
//  - Read latency 1 cycle on both ports; ce low -> q holds. Reads with ce high update q.
//  - Port-2 write (ce2=1, we2=0): lanes with be2[i]=1 take d2, others unchanged. be2=0 is a
//    no-op write. q2 per RDW2: 0 hold, 1 <= {merged word}.
//  - Port-2 read (ce2=1, we2=1): q2 <= mem[a2]; be2 ignored.
//  - Collision a1==a2, ce1=1, port-2 write same cycle: RDW1=0 q1 <= pre-write word;
//    RDW1=1 q1 <= merged word (enabled lanes from d2, others from memory).
//  - Write at a location then read next cycle on either port returns new data (no stall).
//  - Address wrap: none; a1/a2 are full-width, cnt wraps only at sweep end (terminal compare).
// STRUCTURE
//  - dpram_pkg: localparams RDW_OLD=0, RDW_NEW=1; FSM encodings ST_CLEAR, ST_IDLE.
//  - Sub-module dpram_core: raw 2**AW x DW storage, port-1 sync read, port-2 sync read plus
//    per-lane write; inferable as block RAM. Top holds FSM, write mux (sweep vs port 2),
//    collision bypass and q registers.
//  - Sweep shares port-2 write path; port 1 stays a pure read port.
// TESTING
//  1 reset pulse, AW=4 -> ready=0 for 16 sweep cycles, ready=1 on 17th; all 16 reads = CLRV.
//  2 DW=16, write a2=3 d2=16'hA5C3 be2=2'b01 over 16'h1111 -> read a2=3 gives 16'h11C3.
//  3 same-cycle write a2=5 d2=8'h7E, read a1=5: RDW1=0 q1=old(00), RDW1=1 q1=8'h7E.
//  4 RDW2=1 write a2=2 d2=8'h33 -> q2=8'h33 next cycle; RDW2=0 -> q2 unchanged.
//  5 reset asserted at sweep address 9 (after writing 8'hFF everywhere) -> restarts at 0, all = CLRV.
//  6 clr=1 in IDLE after writes -> ready low, 2**AW cycles later all words = CLRV; ce2 writes
//    issued during sweep are discarded.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared constants for the byte-lane dual-port RAM: read-during-write modes and sweep FSM states.
package dpram_pkg;
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;
endpackage

// File: rtl/dpram_core.sv
// Raw 2**AW x DW storage split into 8-bit lanes: port 1 sync read, port 2 sync read + per-lane write.
module dpram_core #(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                re1,
  input  logic [AW-1:0]       a1,
  output logic [DW-1:0]       q1,
  input  logic                re2,
  input  logic                wr2,
  input  logic [DW/8-1:0]     be2,
  input  logic [AW-1:0]       a2,
  input  logic [DW-1:0]       d2,
  output logic [DW-1:0]       q2
);
  localparam int NUM_LANES = DW / 8;
  localparam int DEPTH     = 1 << AW;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] r1, r2;
    logic       lane_wr;

    assign lane_wr = wr2 & be2[i];

    always_ff @(posedge clock)
      if (lane_wr) mem[a2] <= d2[8*i +: 8];

    // Port 2 is write-first per lane, so a write with q2 enabled returns the merged word.
    always_ff @(posedge clock or posedge reset)
      if (reset) begin
        r1 <= '0;
        r2 <= '0;
      end else begin
        if (re1) r1 <= mem[a1];
        if (re2) r2 <= lane_wr ? d2[8*i +: 8] : mem[a2];
      end

    assign q1[8*i +: 8] = r1;
    assign q2[8*i +: 8] = r2;
  end
endmodule

// File: rtl/dpram_bwc.sv
// Dual-port RAM with byte-lane writes, selectable read-during-write and a clear-on-reset sweep.
module dpram_bwc
  import dpram_pkg::*;
#(
  parameter int            AW   = 14,
  parameter int            DW   = 8,
  parameter int            RDW1 = 0,
  parameter int            RDW2 = 0,
  parameter logic [DW-1:0] CLRV = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clr,
  output logic            ready,
  input  logic            ce1,
  input  logic [AW-1:0]   a1,
  output logic [DW-1:0]   q1,
  input  logic            ce2,
  input  logic            we2,
  input  logic [DW/8-1:0] be2,
  input  logic [DW-1:0]   d2,
  input  logic [AW-1:0]   a2,
  output logic [DW-1:0]   q2
);
  localparam int            NUM_LANES = DW / 8;
  localparam logic [AW-1:0] LAST      = '1;

  state_t                 state;
  logic [AW-1:0]          cnt;
  logic                   sweep, user, wr, re1, re2;
  logic [AW-1:0]          wa;
  logic [DW-1:0]          wd, rd1, byp_d;
  logic [NUM_LANES-1:0]   wbe, coll, byp;

  assign sweep = (state == ST_CLEAR);
  assign user  = (state == ST_IDLE);

  // The sweep borrows the port-2 write path; user traffic is dropped until it finishes.
  assign wr  = sweep | (user & ce2 & ~we2);
  assign wa  = sweep ? cnt  : a2;
  assign wd  = sweep ? CLRV : d2;
  assign wbe = sweep ? {NUM_LANES{1'b1}} : be2;
  assign re1 = user & ce1;
  assign re2 = user & ce2 & (we2 | (RDW2 == RDW_NEW));

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= ST_CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR:
          if (cnt == LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
            ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        ST_IDLE:
          if (clr) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
          end
        default: begin
          state <= ST_CLEAR;
          cnt   <= '0;
          ready <= 1'b0;
        end
      endcase
    end

  dpram_core #(.AW(AW), .DW(DW)) u_core (
    .clock (clock),
    .reset (reset),
    .re1   (re1),
    .a1    (a1),
    .q1    (rd1),
    .re2   (re2),
    .wr2   (wr),
    .be2   (wbe),
    .a2    (wa),
    .d2    (wd),
    .q2    (q2)
  );

  // Same-address collision: remember which lanes port 2 overwrote so q1 can show the new bytes.
  assign coll = be2 & {NUM_LANES{(RDW1 == RDW_NEW) && user && ce2 && !we2 && (a1 == a2)}};

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      byp   <= '0;
      byp_d <= '0;
    end else if (re1) begin
      byp   <= coll;
      byp_d <= d2;
    end

  always_comb begin
    q1 = rd1;
    for (int i = 0; i < NUM_LANES; i++)
      if (byp[i]) q1[8*i +: 8] = byp_d[8*i +: 8];
  end
endmodule
